// File: rtl/gfx256_pkg.sv
// Shared types and constants for the gfx256 memory read path.
package gfx256_pkg;

  localparam int GFX_MDW        = 256;
  localparam int GFX_LINE_BYTES = GFX_MDW / 8;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_BUS  = 2'd1,
    RD_DONE = 2'd2
  } gfx256_rd_state_e;

endpackage

// File: rtl/gfx256_rr_arbiter.sv
// Combinational rotate-priority arbiter: picks the first requester after last_grant.
module gfx256_rr_arbiter #(
  parameter int NREQ = 3,
  parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last_grant,
  output logic [GW-1:0]   grant,
  output logic            valid
);

  logic [GW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester after last_grant wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = GW'((int'(last_grant) + i) % NREQ);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gfx256_wbm_reader.sv
// Round-robin read responder: one Wishbone classic read per granted client request,
// full line returned with a single-cycle ack.
module gfx256_wbm_reader
  import gfx256_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int MDW  = GFX_MDW,
  parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*32-1:0] addr_i,
  input  logic [NREQ*32-1:0] sel_i,
  output logic [NREQ-1:0]    ack_o,
  output logic [MDW-1:0]     data_o,
  output logic               err_o,
  output logic               busy_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [31:0]        wbm_adr_o,
  output logic [MDW/8-1:0]   wbm_sel_o,
  input  logic [MDW-1:0]     wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  output gfx256_rd_state_e   dbg_state_o,
  output logic [GW-1:0]      dbg_last_grant_o
);

  // Client handshake: req_i[k] is a level held until ack_o[k] pulses for one cycle;
  // data_o/err_o are valid only in that cycle, and the following DONE cycle lets the
  // client drop req_i before the arbiter samples again.

  localparam int LINE_BYTES = MDW / 8;

  gfx256_rd_state_e        state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_q, last_d;
  logic [31:0]             adr_q, adr_d;
  logic [LINE_BYTES-1:0]   sel_q, sel_d;
  logic                    cyc_q, cyc_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic [NREQ-1:0]         ack_q, ack_d;
  logic [MDW-1:0]          data_q, data_d;

  logic [GW-1:0]           arb_grant;
  logic                    arb_valid;
  logic [31:0]             req_adr;
  logic [31:0]             req_sel;

  gfx256_rr_arbiter #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_arb (
    .req        (req_i),
    .last_grant (last_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  always_comb begin
    req_adr = '0;
    req_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_grant == GW'(k)) begin
        req_adr = addr_i[32*k +: 32];
        req_sel = sel_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    cyc_d   = cyc_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    ack_d   = '0;
    data_d  = data_q;
    case (state_q)
      RD_IDLE: begin
        cyc_d  = 1'b0;
        busy_d = 1'b0;
        adr_d  = '0;
        sel_d  = '0;
        if (arb_valid) begin
          state_d = RD_BUS;
          grant_d = arb_grant;
          last_d  = arb_grant;
          adr_d   = req_adr & ~32'(LINE_BYTES - 1);
          sel_d   = LINE_BYTES'(req_sel);
          cyc_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RD_BUS: begin
        // An error wins over a simultaneous ack: the line is discarded.
        if (wbm_err_i) begin
          data_d         = '0;
          ack_d[grant_q] = 1'b1;
          err_d          = 1'b1;
          cyc_d          = 1'b0;
          state_d        = RD_DONE;
        end else if (wbm_ack_i) begin
          data_d         = wbm_dat_i;
          ack_d[grant_q] = 1'b1;
          cyc_d          = 1'b0;
          state_d        = RD_DONE;
        end
      end
      RD_DONE: begin
        busy_d  = 1'b0;
        adr_d   = '0;
        sel_d   = '0;
        state_d = RD_IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RD_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NREQ - 1);
      adr_q   <= '0;
      sel_q   <= '0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  assign ack_o            = ack_q;
  assign data_o           = data_q;
  assign err_o            = err_q;
  assign busy_o           = busy_q;
  assign wbm_cyc_o        = cyc_q;
  assign wbm_stb_o        = cyc_q;
  assign wbm_we_o         = 1'b0;
  assign wbm_adr_o        = adr_q;
  assign wbm_sel_o        = sel_q;
  assign dbg_state_o      = state_q;
  assign dbg_last_grant_o = last_q;

endmodule

// File: tb/tb_gfx256_wbm_reader.sv
// Directed bench for gfx256_wbm_reader: vector table of single transactions plus
// hand-written round-robin, reset-mid-bus and withdrawn-request sequences.
module tb_gfx256_wbm_reader;
  import gfx256_pkg::*;

  localparam logic [31:0] A0 = 32'h0000_1007;
  localparam logic [31:0] A1 = 32'h0001_2345;
  localparam logic [31:0] A2 = 32'hDEAD_BEEF;
  localparam logic [31:0] S0 = 32'hFFFF_FFFF;
  localparam logic [31:0] S1 = 32'h0000_00FF;
  localparam logic [31:0] S2 = 32'hF0F0_0F0F;

  logic         clk;
  logic         rst_i;
  logic [2:0]   req_i;
  logic [95:0]  addr_i;
  logic [95:0]  sel_i;
  logic [2:0]   ack_o;
  logic [255:0] data_o;
  logic         err_o;
  logic         busy_o;
  logic         wbm_cyc_o;
  logic         wbm_stb_o;
  logic         wbm_we_o;
  logic [31:0]  wbm_adr_o;
  logic [31:0]  wbm_sel_o;
  logic [255:0] wbm_dat_i;
  logic         wbm_ack_i;
  logic         wbm_err_i;
  gfx256_rd_state_e dbg_state_o;
  logic [1:0]   dbg_last_grant_o;

  logic slave_ack;
  logic force_ack;
  logic slave_en;
  logic slave_err;
  int   slave_wait;

  int total;
  int bad;

  typedef struct {
    logic [2:0]  req;
    int          wt;
    bit          er;
    logic [2:0]  exp_ack;
    logic [31:0] exp_adr;
    logic [31:0] exp_sel;
  } vec_t;

  vec_t vt[8];

  gfx256_wbm_reader dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_i            (req_i),
    .addr_i           (addr_i),
    .sel_i            (sel_i),
    .ack_o            (ack_o),
    .data_o           (data_o),
    .err_o            (err_o),
    .busy_o           (busy_o),
    .wbm_cyc_o        (wbm_cyc_o),
    .wbm_stb_o        (wbm_stb_o),
    .wbm_we_o         (wbm_we_o),
    .wbm_adr_o        (wbm_adr_o),
    .wbm_sel_o        (wbm_sel_o),
    .wbm_dat_i        (wbm_dat_i),
    .wbm_ack_i        (wbm_ack_i),
    .wbm_err_i        (wbm_err_i),
    .dbg_state_o      (dbg_state_o),
    .dbg_last_grant_o (dbg_last_grant_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign wbm_ack_i = slave_ack | force_ack;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {4{a, ~a}};
  endfunction

  // Slave model: responds after slave_wait extra cycles of stb.
  initial begin
    int cnt;
    cnt       = 0;
    slave_ack = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      slave_ack = 1'b0;
      wbm_err_i = 1'b0;
      if (slave_en && wbm_cyc_o && wbm_stb_o) begin
        if (cnt >= slave_wait) begin
          if (slave_err) wbm_err_i = 1'b1;
          else           slave_ack = 1'b1;
          wbm_dat_i = line_of(wbm_adr_o);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input string tag, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %0h want %0h", nm, tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_i && !$onehot0(ack_o)) begin
      bad++;
      $display("FAIL onehot_ack: got %b want at most one bit", ack_o);
    end
    if (!rst_i && err_o && ack_o == 3'b000) begin
      bad++;
      $display("FAIL err_without_ack: got err=1 ack=%b want ack pulse", ack_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = '0;
    repeat (3) tick();
    rst_i = 1'b0;
  endtask

  // Wait for an ack pulse; returns the ack vector (0 on timeout).
  task automatic wait_ack(input string nm, output logic [2:0] seen);
    seen = '0;
    for (int i = 0; i < 30 && seen == 3'b000; i++) begin
      tick();
      seen = ack_o;
    end
    chk(nm, "ack_seen", 256'(seen != 3'b000), 256'(1));
  endtask

  // ---------------- driver: one table transaction ----------------
  task automatic run_vec(input vec_t v, input string nm);
    logic [31:0]  adr0;
    logic [31:0]  sel0;
    logic [255:0] exp_data;
    bit           stable;
    bit           got;
    int           busy_n;
    req_i      = v.req;
    slave_wait = v.wt;
    slave_err  = v.er;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (wbm_cyc_o) got = 1'b1;
    end
    chk(nm, "cyc_rise", 256'(got), 256'(1));
    if (!got) begin
      req_i = '0;
      return;
    end
    chk(nm, "adr", 256'(wbm_adr_o), 256'(v.exp_adr));
    chk(nm, "sel", 256'(wbm_sel_o), 256'(v.exp_sel));
    chk(nm, "we_stb", 256'({wbm_we_o, wbm_stb_o}), 256'(2'b01));
    adr0   = wbm_adr_o;
    sel0   = wbm_sel_o;
    stable = 1'b1;
    busy_n = busy_o ? 1 : 0;
    got    = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (busy_o) busy_n++;
      if (ack_o != 3'b000) got = 1'b1;
      else if (!(wbm_cyc_o && wbm_stb_o && wbm_adr_o == adr0 && wbm_sel_o == sel0))
        stable = 1'b0;
    end
    exp_data = v.er ? 256'd0 : line_of(v.exp_adr);
    chk(nm, "bus_stable", 256'(stable), 256'(1));
    chk(nm, "ack", 256'(ack_o), 256'(v.exp_ack));
    chk(nm, "err", 256'(err_o), 256'(v.er));
    chk(nm, "data", data_o, exp_data);
    chk(nm, "cyc_drop", 256'(wbm_cyc_o), 256'(0));
    chk(nm, "busy_cycles", 256'(busy_n), 256'(v.wt + 2));
    req_i = '0;
    tick();
    chk(nm, "ack_end", 256'({ack_o, err_o}), 256'(0));
    chk(nm, "busy_end", 256'(busy_o), 256'(0));
    chk(nm, "idle", 256'(dbg_state_o), 256'(RD_IDLE));
    chk(nm, "data_hold", data_o, exp_data);
  endtask

  // ---------------- test body ----------------
  initial begin
    logic [2:0] seen;
    logic [2:0] exp_rr[6];
    total      = 0;
    bad        = 0;
    force_ack  = 1'b0;
    slave_en   = 1'b1;
    slave_err  = 1'b0;
    slave_wait = 0;
    addr_i     = {A2, A1, A0};
    sel_i      = {S2, S1, S0};
    req_i      = '0;

    vt[0] = '{req: 3'b010, wt: 1, er: 1'b0, exp_ack: 3'b010, exp_adr: 32'h0001_2340, exp_sel: S1};
    vt[1] = '{req: 3'b111, wt: 0, er: 1'b0, exp_ack: 3'b100, exp_adr: 32'hDEAD_BEE0, exp_sel: S2};
    vt[2] = '{req: 3'b111, wt: 0, er: 1'b0, exp_ack: 3'b001, exp_adr: 32'h0000_1000, exp_sel: S0};
    vt[3] = '{req: 3'b101, wt: 0, er: 1'b0, exp_ack: 3'b100, exp_adr: 32'hDEAD_BEE0, exp_sel: S2};
    vt[4] = '{req: 3'b011, wt: 5, er: 1'b0, exp_ack: 3'b001, exp_adr: 32'h0000_1000, exp_sel: S0};
    vt[5] = '{req: 3'b011, wt: 0, er: 1'b1, exp_ack: 3'b010, exp_adr: 32'h0001_2340, exp_sel: S1};
    vt[6] = '{req: 3'b100, wt: 2, er: 1'b0, exp_ack: 3'b100, exp_adr: 32'hDEAD_BEE0, exp_sel: S2};
    vt[7] = '{req: 3'b001, wt: 0, er: 1'b0, exp_ack: 3'b001, exp_adr: 32'h0000_1000, exp_sel: S0};
    exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    do_reset();
    chk("reset", "ack_err_busy", 256'({ack_o, err_o, busy_o}), 256'(0));
    chk("reset", "cyc_stb", 256'({wbm_cyc_o, wbm_stb_o}), 256'(0));
    chk("reset", "adr_sel", 256'({wbm_adr_o, wbm_sel_o}), 256'(0));
    chk("reset", "data", data_o, 256'd0);
    chk("reset", "state", 256'(dbg_state_o), 256'(RD_IDLE));
    chk("reset", "last_grant", 256'(dbg_last_grant_o), 256'(2));

    for (int i = 0; i < 8; i++) begin
      run_vec(vt[i], $sformatf("vec%0d", i));
    end

    // Round-robin with all clients continuously requesting.
    do_reset();
    slave_wait = 0;
    slave_err  = 1'b0;
    req_i      = 3'b111;
    for (int n = 0; n < 6; n++) begin
      wait_ack($sformatf("rr%0d", n), seen);
      chk($sformatf("rr%0d", n), "grant", 256'(seen), 256'(exp_rr[n]));
      req_i = req_i & ~seen;
      tick();
      req_i = 3'b111;
    end
    req_i = '0;
    repeat (4) tick();

    // Reset while the bus cycle is outstanding, then a stray ack.
    slave_en = 1'b0;
    req_i    = 3'b001;
    seen     = '0;
    for (int i = 0; i < 10 && !wbm_cyc_o; i++) tick();
    chk("rst_bus", "cyc_up", 256'(wbm_cyc_o), 256'(1));
    repeat (2) tick();
    rst_i = 1'b1;
    req_i = '0;
    tick();
    rst_i = 1'b0;
    chk("rst_bus", "cyc_stb", 256'({wbm_cyc_o, wbm_stb_o}), 256'(0));
    chk("rst_bus", "ack_busy", 256'({ack_o, busy_o}), 256'(0));
    chk("rst_bus", "state", 256'(dbg_state_o), 256'(RD_IDLE));
    chk("rst_bus", "last_grant", 256'(dbg_last_grant_o), 256'(2));
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    chk("rst_bus", "stray_ack", 256'({ack_o, err_o, wbm_cyc_o}), 256'(0));
    chk("rst_bus", "state_after", 256'(dbg_state_o), 256'(RD_IDLE));
    chk("rst_bus", "data", data_o, 256'd0);
    slave_en = 1'b1;

    // Client 2 withdraws mid-bus while client 0 raises its request.
    slave_wait = 3;
    req_i      = 3'b100;
    for (int i = 0; i < 10 && !wbm_cyc_o; i++) tick();
    chk("withdraw", "adr2", 256'(wbm_adr_o), 256'(32'hDEAD_BEE0));
    tick();
    req_i = 3'b001;
    wait_ack("withdraw_a", seen);
    chk("withdraw", "ack2", 256'(seen), 256'(3'b100));
    chk("withdraw", "data2", data_o, line_of(32'hDEAD_BEE0));
    wait_ack("withdraw_b", seen);
    req_i = '0;
    chk("withdraw", "ack0", 256'(seen), 256'(3'b001));
    chk("withdraw", "data0", data_o, line_of(32'h0000_1000));
    repeat (3) tick();
    chk("withdraw", "idle", 256'({busy_o, ack_o}), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
